decode_queue: RTL and testbench

Parametrised instruction buffer between the fetch register and the decoders. It decouples a FETCH_WIDTH-wide fetch from a DECODE_WIDTH-wide decode stage. Each entry holds a (pc, raw_instr) pair. Entries leave in program order. A pipeline redirect (taken branch, jump or jr resolved in decode/execute) flushes all entries in one cycle.

---
 rtl/decode_queue.sv | 116 +++++++++++
 tb/tb_decode_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Instruction buffer between fetch and decode: FETCH_WIDTH lanes in, DECODE_WIDTH
// lanes out, program order, single-cycle flush on redirect.
module decode_queue #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned DECODE_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [FETCH_WIDTH-1:0]              in_valid,
  input  logic [FETCH_WIDTH*XLEN-1:0]         in_pc,
  input  logic [FETCH_WIDTH*32-1:0]           in_instr,
  output logic                                in_ready,
  output logic [DECODE_WIDTH-1:0]             out_valid,
  output logic [DECODE_WIDTH*XLEN-1:0]        out_pc,
  output logic [DECODE_WIDTH*32-1:0]          out_instr,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0]   deq_num,
  output logic [$clog2(DEPTH+1)-1:0]          count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] enq_n;
  logic [CW-1:0] deq_eff;
  logic [CW-1:0] count_next;
  logic [PW-1:0] wr_idx [FETCH_WIDTH];
  logic [PW-1:0] rd_idx [DECODE_WIDTH];

  // Enqueue size: the whole thermometer group, or nothing.
  always_comb begin
    enq_n = '0;
    if (in_ready && !flush) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        enq_n = enq_n + CW'(in_valid[i]);
      end
    end
  end

  // Dequeue size clamped to lane count and occupancy.
  always_comb begin
    deq_eff = CW'(deq_num);
    if (deq_eff > CW'(DECODE_WIDTH)) begin
      deq_eff = CW'(DECODE_WIDTH);
    end
    if (deq_eff > count) begin
      deq_eff = count;
    end
    count_next = count + enq_n - deq_eff;
  end

  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i] = tail + PW'(i);
    end
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      rd_idx[i] = head + PW'(i);
    end
  end

  // Storage has no reset; only occupied slots are ever presented.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (!reset && (CW'(i) < enq_n)) begin
        pc_mem[wr_idx[i]]    <= in_pc[i*XLEN +: XLEN];
        instr_mem[wr_idx[i]] <= in_instr[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      head     <= head + PW'(deq_eff);
      tail     <= tail + PW'(enq_n);
      count    <= count_next;
      in_ready <= (count_next <= CW'(DEPTH - FETCH_WIDTH));
    end
  end

  // Read side depends only on registered pointers, count and storage.
  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_instr = {DECODE_WIDTH{NOP}};
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      if (count > CW'(i)) begin
        out_valid[i]            = 1'b1;
        out_pc[i*XLEN +: XLEN]  = pc_mem[rd_idx[i]];
        out_instr[i*32 +: 32]   = instr_mem[rd_idx[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count <= CW'(DEPTH));
      if (in_ready) begin
        assert ((in_valid & (in_valid + FETCH_WIDTH'(1))) == '0);
      end
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a queue-based reference model.
module tb_decode_queue;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned FW    = 2;
  localparam int unsigned DW    = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic              clk;
  logic              reset;
  logic              flush;
  logic [FW-1:0]     in_valid;
  logic [FW*XLEN-1:0] in_pc;
  logic [FW*32-1:0]  in_instr;
  logic              in_ready;
  logic [DW-1:0]     out_valid;
  logic [DW*XLEN-1:0] out_pc;
  logic [DW*32-1:0]  out_instr;
  logic [1:0]        deq_num;
  logic [3:0]        count;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .deq_num(deq_num), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit done  = 0;

  // Reference: the queue contents in program order.
  logic [63:0] m_pc [$];
  logic [31:0] m_in [$];

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return {pc[31:2] ^ 30'h2AAA_5555, 2'b11};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int sz;
    int n;
    bit rdy;
    if (reset || flush) begin
      m_pc.delete();
      m_in.delete();
    end else begin
      sz  = m_pc.size();
      rdy = (DEPTH - sz) >= FW;
      n   = int'(deq_num);
      if (n > DW) n = DW;
      if (n > sz) n = sz;
      for (int k = 0; k < n; k++) begin
        void'(m_pc.pop_front());
        void'(m_in.pop_front());
      end
      if (rdy) begin
        for (int i = 0; i < FW; i++) begin
          if (in_valid[i]) begin
            m_pc.push_back(in_pc[i*XLEN +: XLEN]);
            m_in.push_back(in_instr[i*32 +: 32]);
          end
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [1:0] v,
                       input logic [63:0] pc0, input logic [63:0] pc1, input logic [1:0] dq);
    reset    = r;
    flush    = f;
    in_valid = v;
    in_pc    = {pc1, pc0};
    in_instr = {instr_of(pc1), instr_of(pc0)};
    deq_num  = dq;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Every-cycle comparison against the model, on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("count", 64'(count), 64'(m_pc.size()));
        chk("in_ready", 64'(in_ready), 64'((DEPTH - m_pc.size()) >= FW));
        for (int i = 0; i < DW; i++) begin
          chk("out_valid", 64'(out_valid[i]), 64'(i < m_pc.size()));
          chk("out_pc", out_pc[i*XLEN +: XLEN], (i < m_pc.size()) ? m_pc[i] : 64'h0);
          chk("out_instr", 64'(out_instr[i*32 +: 32]), 64'((i < m_pc.size()) ? m_in[i] : NOP));
        end
      end
    end
  end

  initial begin
    logic [63:0] pc_next;
    logic [1:0]  v;
    logic [1:0]  dq;
    logic [63:0] rp;
    reset = 1'b1; flush = 1'b0; in_valid = '0; in_pc = '0; in_instr = '0; deq_num = '0;

    // Reset held two cycles, then idle.
    drive(1, 0, 2'b00, 0, 0, 0);
    drive(1, 0, 2'b00, 0, 0, 0);
    drive(0, 0, 2'b00, 0, 0, 0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_nop0", 64'(out_instr[31:0]), 64'(NOP));
    chk("rst_nop1", 64'(out_instr[63:32]), 64'(NOP));

    // Fill to full; fifth group is refused.
    for (int g = 0; g < 4; g++) begin
      drive(0, 0, 2'b11, 64'h8000_0000 + 64'(8*g), 64'h8000_0004 + 64'(8*g), 0);
      chk("fill_count", 64'(count), 64'(2*g + 2));
      chk("fill_ready", 64'(in_ready), (g < 3) ? 64'd1 : 64'd0);
    end
    drive(0, 0, 2'b11, 64'h8000_0020, 64'h8000_0024, 0);
    chk("full_hold_count", 64'(count), 64'd8);
    chk("full_head_pc0", out_pc[63:0], 64'h8000_0000);
    chk("full_head_pc1", out_pc[127:64], 64'h8000_0004);

    // Drain two per cycle while fetch retries its held group; pointers wrap.
    pc_next = 64'h8000_0020;
    for (int k = 1; k <= 6; k++) begin
      v = {1'b1, 1'b1};
      if (in_ready) begin
        drive(0, 0, v, pc_next, pc_next + 64'd4, 2);
        pc_next = pc_next + 64'd8;
      end else begin
        drive(0, 0, v, pc_next, pc_next + 64'd4, 2);
      end
      chk("drain_pc0", out_pc[63:0], 64'h8000_0000 + 64'(8*k));
      chk("drain_pc1", out_pc[127:64], 64'h8000_0004 + 64'(8*k));
      chk("drain_count", 64'(count), 64'd6);
    end

    // Empty the queue, then a single-lane fetch with an over-sized dequeue.
    for (int k = 0; k < 3; k++) drive(0, 0, 2'b00, 0, 0, 2);
    chk("empty_count", 64'(count), 64'd0);
    drive(0, 0, 2'b01, 64'h2000, 64'h0, 0);
    drive(0, 0, 2'b01, 64'h2004, 64'h0, 2);
    chk("clamp_count", 64'(count), 64'd1);
    chk("clamp_pc0", out_pc[63:0], 64'h2004);
    chk("clamp_valid", 64'(out_valid), 64'd1);
    chk("clamp_nop1", 64'(out_instr[63:32]), 64'(NOP));

    // Flush with concurrent enqueue and dequeue.
    drive(0, 0, 2'b11, 64'h3000, 64'h3004, 0);
    drive(0, 0, 2'b11, 64'h3008, 64'h300C, 0);
    chk("pre_flush_count", 64'(count), 64'd5);
    drive(0, 1, 2'b11, 64'h3010, 64'h3014, 2);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    drive(0, 0, 2'b00, 0, 0, 0);
    chk("post_flush_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of traffic.
    for (int g = 0; g < 3; g++) drive(0, 0, 2'b11, 64'h4000 + 64'(8*g), 64'h4004 + 64'(8*g), 0);
    drive(0, 0, 2'b01, 64'h4018, 64'h0, 0);
    chk("pre_rst_count", 64'(count), 64'd7);
    drive(1, 0, 2'b11, 64'h5000, 64'h5004, 0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 2'b01, 64'h1000, 64'h0, 0);
    chk("after_rst_pc0", out_pc[63:0], 64'h1000);
    chk("after_rst_valid", 64'(out_valid), 64'd1);

    // Random traffic; alternating blocks favour filling or draining.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 2))
        0: v = 2'b00;
        1: v = 2'b01;
        default: v = 2'b11;
      endcase
      dq = ((c / 200) % 2 == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      rp = {32'($urandom), 32'($urandom) & 32'hFFFF_FFFC};
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0), v,
            rp, rp + 64'd4, dq);
    end

    @(negedge clk);
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
